mem_access_unit: RTL

- MEM-stage data-memory initiator for the RV32I pipeline. It sits between the EX/MEM register and the data cache.
- Turns EX/MEM load/store control into a held-request cache transaction with byte mask and lane-shifted write data.
- Stalls the pipeline until the cache responds, then sign/zero-extends and aligns load data.
- Produces mem_rdata, the load-data input consumed by the MEM/WB register.

---
 rtl/mem_access_types.sv | 8 +
 rtl/rv32i_types.sv | 5 +
 rtl/mem_load_align.sv | 24 ++
 rtl/mem_access_unit.sv | 79 +++++++
 4 files changed

// File: rtl/mem_access_types.sv
// mem_access_types: MEM-stage access FSM states and byte-enable masks
package mem_access_types;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
  localparam logic [3:0] MBE_NONE = 4'b0000;
  localparam logic [3:0] MBE_BYTE = 4'b0001;
  localparam logic [3:0] MBE_HALF = 4'b0011;
  localparam logic [3:0] MBE_WORD = 4'b1111;
endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: RV32I load/store funct3 encodings
package rv32i_types;
  typedef enum logic [2:0] {LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101} load_funct3_t;
  typedef enum logic [2:0] {SB = 3'b000, SH = 3'b001, SW = 3'b010} store_funct3_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the byte/half lane of a raw cache word by offset and sign/zero-extends it per funct3
module mem_load_align
  import rv32i_types::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] fmt
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = raw[{off, 3'b000} +: 8];
  assign h = off[1] ? raw[31:16] : raw[15:0];
  always_comb begin
    case (funct3)
      LB:      fmt = {{24{b[7]}}, b};
      LBU:     fmt = {24'd0, b};
      LH:      fmt = {{16{h[15]}}, h};
      LHU:     fmt = {16'd0, h};
      LW:      fmt = raw;
      default: fmt = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-cache initiator (held request, byte mask, store lane shift, load align; rst async active-low; MEM_MISALIGN_TRAP_EN enables misalignment trap)
module mem_access_unit
  import rv32i_types::*;
  import mem_access_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_valid,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic [2:0]        exmem_funct3,
  input  logic [ADDR_W-1:0] exmem_alu_out,
  input  logic [ADDR_W-1:0] exmem_rs2_out,
  input  logic              memwb_load,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [3:0]        dmem_mbe,
  output logic [ADDR_W-1:0] dmem_wdata,
  input  logic              dmem_resp,
  input  logic [ADDR_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              mem_misalign
);
  mem_state_t        state;
  logic [ADDR_W-1:0] held_rdata;
  logic [ADDR_W-1:0] fmt;
  logic [1:0]        off;
  logic              access, misalign, go, rd, wr, busy;
  assign off = exmem_alu_out[1:0];
  assign access = exmem_valid & (exmem_mem_read | exmem_mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (exmem_funct3[1:0] == 2'b01 ? off[0] : exmem_funct3 == 3'b010 ? |off : 1'b0);
`else
  assign misalign = 1'b0;
`endif
  // rst gates the combinational side so requests drop in the same cycle reset is asserted
  assign go = access & ~misalign & rst;
  assign rd = go & exmem_mem_read;
  assign wr = go & ~exmem_mem_read & exmem_mem_write;
  assign busy = state != DONE;
  assign dmem_read = rd & busy;
  assign dmem_write = wr & busy;
  assign dmem_address = {exmem_alu_out[ADDR_W-1:2], 2'b00};
  assign dmem_mbe = rd ? MBE_WORD : !wr ? MBE_NONE :
                    exmem_funct3 == SB ? MBE_BYTE << off :
                    exmem_funct3 == SH ? MBE_HALF << {off[1], 1'b0} :
                    exmem_funct3 == SW ? MBE_WORD : MBE_NONE;
  assign dmem_wdata = exmem_funct3 == SB ? exmem_rs2_out << {off, 3'b000} :
                      exmem_funct3 == SH ? exmem_rs2_out << {off[1], 4'b0000} : exmem_rs2_out;
  assign mem_stall = go & busy & ~dmem_resp;
  assign mem_misalign = misalign & rst;
  assign mem_rdata = state == DONE ? held_rdata : rd ? fmt : '0;
  mem_load_align u_align (
    .raw   (dmem_rdata),
    .funct3(exmem_funct3),
    .off   (off),
    .fmt   (fmt)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      held_rdata <= '0;
    end else begin
      case (state)
        IDLE, WAIT:
          if (go & dmem_resp) begin
            held_rdata <= rd ? fmt : '0;
            state      <= memwb_load ? IDLE : DONE;
          end else if (go) state <= WAIT;
        DONE:    if (memwb_load) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
